// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU), one quotient bit per cycle.
// result_o packs {remainder, quotient}; a zero divisor yields an all-zero result.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        op1_neg, op2_neg;
    logic [31:0] op1_mag, op2_mag;
    logic [32:0] sh_rem;
    logic [31:0] sh_quo;
    logic [31:0] sub_b;
    logic [32:0] trial;
    logic [8:0]  carry;
    logic [4:0]  slice;
    logic [31:0] iter_rem, iter_quo;
    logic [31:0] rem_fin, quo_fin;

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] g, p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign op1_neg = signed_div_i & opdata1_i[31];
    assign op2_neg = signed_div_i & opdata2_i[31];
    assign op1_mag = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_mag = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

    // Partial remainder stays below the divisor, so 32 stored bits suffice.
    assign sh_rem = {rem_q, quo_q[31]};
    assign sh_quo = {quo_q[30:0], 1'b0};
    assign sub_b  = ~divisor_q;

    // trial = sh_rem - {1'b0, divisor}: eight CLA slices plus a top-bit full adder.
    always_comb begin
        carry    = '0;
        slice    = '0;
        trial    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            slice           = cla4(sh_rem[4*i +: 4], sub_b[4*i +: 4], carry[i]);
            trial[4*i +: 4] = slice[3:0];
            carry[i+1]      = slice[4];
        end
        trial[32] = sh_rem[32] ^ 1'b1 ^ carry[8];
    end

    assign iter_rem = trial[32] ? sh_rem[31:0] : trial[31:0];
    assign iter_quo = {sh_quo[31:1], ~trial[32]};
    assign quo_fin  = neg_quo_q ? (~iter_quo + 32'd1) : iter_quo;
    assign rem_fin  = neg_rem_q ? (~iter_rem + 32'd1) : iter_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            StIdle: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    divisor_d = op2_mag;
                    quo_d     = op1_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    state_d   = (opdata2_i == 32'd0) ? StByZero : StOn;
                end
            end
            StByZero: begin
                state_d  = StEnd;
                result_d = '0;
                ready_d  = 1'b1;
            end
            StOn: begin
                rem_d = iter_rem;
                quo_d = iter_quo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d  = StEnd;
                    result_d = {rem_fin, quo_fin};
                    ready_d  = 1'b1;
                end
            end
            StEnd: begin
                if (!start_i) begin
                    state_d  = StIdle;
                    ready_d  = 1'b0;
                    result_d = '0;
                    cnt_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pipeline flush wins over any other transition.
        if (annul_i && (state_q != StIdle)) begin
            state_d  = StIdle;
            ready_d  = 1'b0;
            result_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: unsigned/signed results, zero divisor,
// overflow corner, annul and asynchronous reset behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        annul;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .annul_i      (annul),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .result_o     (result),
        .ready_o      (ready)
    );

    // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full request: accept, scramble operands, expect ready exactly 32 edges later,
    // hold while start stays high, clear on the edge after start drops.
    task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        step();
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~sgn;
        repeat (31) step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL %s early_ready: got %b want 0", name, ready);
        end
        step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b want 1", name, ready);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, result, exp);
        end
        step();
        checks++;
        if (ready !== 1'b1 || result !== exp) begin
            errors++;
            $display("FAIL %s hold: got ready=%b result=%h want 1 %h", name, ready, result, exp);
        end
        start = 1'b0;
        step();
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL %s release: got ready=%b result=%h want 0 0", name, ready, result);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL reset_async: got ready=%b result=%h want 0 0", ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL reset_idle: got ready=%b result=%h want 0 0", ready, result);
        end
    endtask

    task automatic test_divu();
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF});
        do_div("divu_max_64k", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000,
               {32'h0000_FFFF, 32'h0000_FFFF});
    endtask

    task automatic test_div_signed();
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        do_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
               {32'hFFFF_FFFE, 32'h0000_000E});
        do_div("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    endtask

    task automatic test_byzero();
        signed_div = 1'b0;
        opdata1    = 32'h1234_5678;
        opdata2    = 32'h0;
        start      = 1'b1;
        step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL byzero_early: got %b want 0", ready);
        end
        step();
        checks++;
        if (ready !== 1'b1 || result !== 64'h0) begin
            errors++;
            $display("FAIL byzero_done: got ready=%b result=%h want 1 0", ready, result);
        end
        start = 1'b0;
        step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL byzero_release: got %b want 0", ready);
        end
    endtask

    task automatic test_annul();
        logic seen_ready;
        seen_ready = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        step();
        repeat (10) begin
            step();
            if (ready === 1'b1) seen_ready = 1'b1;
        end
        annul = 1'b1;
        start = 1'b0;
        step();
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL annul_idle: got ready=%b result=%h want 0 0", ready, result);
        end
        annul = 1'b0;
        step();
        if (ready === 1'b1) seen_ready = 1'b1;
        checks++;
        if (seen_ready !== 1'b0) begin
            errors++;
            $display("FAIL annul_no_ready: got %b want 0", seen_ready);
        end
        do_div("after_annul", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15});
    endtask

    task automatic test_async_reset();
        logic seen_ready;
        // Mid-operation reset, applied between edges.
        signed_div = 1'b0;
        opdata1    = 32'd500;
        opdata2    = 32'd7;
        start      = 1'b1;
        step();
        repeat (20) step();
        rst   = 1'b1;
        start = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid: got ready=%b result=%h want 0 0", ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready === 1'b1) seen_ready = 1'b1;
        end
        checks++;
        if (seen_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_ready: got %b want 0", seen_ready);
        end
        // Reset while a result is held must clear it before the next edge.
        opdata1 = 32'd9;
        opdata2 = 32'd2;
        start   = 1'b1;
        step();
        repeat (32) step();
        checks++;
        if (ready !== 1'b1 || result !== {32'd1, 32'd4}) begin
            errors++;
            $display("FAIL rst_pre_end: got ready=%b result=%h want 1 %h", ready, result,
                     {32'd1, 32'd4});
        end
        rst   = 1'b1;
        start = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("FAIL rst_end: got ready=%b result=%h want 0 0", ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        do_div("after_rst", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
    endtask

    task automatic test_back_to_back();
        do_div("b2b_first", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});
        do_div("b2b_second", 1'b1, 32'd123, 32'hFFFF_FFF6, {32'd3, 32'hFFFF_FFF4});
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_byzero();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
